// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite memory slave with wait states; AHB_SLV_ERR_EN enables two-cycle ERROR responses
module ahb_slave_mem #(
    parameter int          MEM_WORDS   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Hwrite,
    input  logic [2:0]  Hsize,
    input  logic [1:0]  Htrans,
    input  logic [2:0]  Hburst,
    input  logic [31:0] Haddr,
    input  logic        Hreadyin,
    input  logic [31:0] Hwdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t          state;
    logic [3:0]      count;
    logic            valid;
    logic            a_write;
    logic [1:0]      a_size;
    logic [1:0]      a_lane;
    logic [AW-1:0]   a_idx;
    logic            a_err;
    logic            ready_q;
    logic [31:0]     mem [MEM_WORDS];
    logic [3:0]      be;
    logic            in_range;
    logic            misalign;
    logic            illegal;
    logic            complete_ok;
    logic            unused_bits;

    // Burst type is not interpreted and only Htrans[1] distinguishes active transfers
    assign unused_bits = ^{Hburst, Htrans[0]};

    // Address-phase legality: window match (base is aligned to the window size), size, alignment
    assign in_range = (Haddr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign misalign = ((Hsize == 3'd1) && Haddr[0]) || ((Hsize == 3'd2) && (Haddr[1:0] != 2'b00));
    assign illegal  = !in_range || (Hsize > 3'd2) || misalign;

    // A legal transfer's data phase is completing in this cycle
    assign complete_ok = ready_q && (state == S_DATA) && valid && !a_err;

    assign Hreadyout = ready_q;
    assign Hrdata    = (complete_ok && !a_write) ? mem[a_idx] : 32'h0;

    // Little-endian byte lanes touched by the registered transfer
    always_comb begin
        be = 4'b0000;
        case (a_size)
            2'd0:    be[a_lane] = 1'b1;
            2'd1:    be = a_lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Memory write commits at the edge ending the completing data phase; contents are not reset
    always_ff @(posedge clock) begin
        if (complete_ok && a_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[a_idx][8*b +: 8] <= Hwdata[8*b +: 8];
            end
        end
    end

`ifdef AHB_SLV_ERR_EN
    logic [1:0] resp_q;
    assign Hresp = resp_q;

    // Response FSM: wait-state countdown, two-cycle ERROR, and pipelined address sampling
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= 4'd0;
            valid   <= 1'b0;
            a_write <= 1'b0;
            a_size  <= 2'd0;
            a_lane  <= 2'd0;
            a_idx   <= '0;
            a_err   <= 1'b0;
            ready_q <= 1'b1;
            resp_q  <= 2'b00;
        end else if (state == S_DATA && count != 4'd0) begin
            count   <= count - 4'd1;
            ready_q <= (count == 4'd1);
        end else if (state == S_ERR1) begin
            // Hreadyin is ignored here; the second ERROR cycle always follows
            state   <= S_ERR2;
            ready_q <= 1'b1;
            resp_q  <= 2'b01;
        end else if (Hreadyin && Htrans[1]) begin
            valid   <= 1'b1;
            a_write <= Hwrite;
            a_size  <= Hsize[1:0];
            a_lane  <= Haddr[1:0];
            a_idx   <= Haddr[AW+1:2];
            a_err   <= illegal;
            if (illegal) begin
                state   <= S_ERR1;
                count   <= 4'd0;
                ready_q <= 1'b0;
                resp_q  <= 2'b01;
            end else begin
                state   <= S_DATA;
                count   <= 4'(WAIT_STATES);
                ready_q <= (WAIT_STATES == 0);
                resp_q  <= 2'b00;
            end
        end else begin
            valid   <= 1'b0;
            state   <= S_IDLE;
            count   <= 4'd0;
            ready_q <= 1'b1;
            resp_q  <= 2'b00;
        end
    end
`else
    assign Hresp = 2'b00;

    // Response FSM: wait-state countdown and pipelined address sampling; illegal transfers use DATA timing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= 4'd0;
            valid   <= 1'b0;
            a_write <= 1'b0;
            a_size  <= 2'd0;
            a_lane  <= 2'd0;
            a_idx   <= '0;
            a_err   <= 1'b0;
            ready_q <= 1'b1;
        end else if (state == S_DATA && count != 4'd0) begin
            count   <= count - 4'd1;
            ready_q <= (count == 4'd1);
        end else if (Hreadyin && Htrans[1]) begin
            valid   <= 1'b1;
            a_write <= Hwrite;
            a_size  <= Hsize[1:0];
            a_lane  <= Haddr[1:0];
            a_idx   <= Haddr[AW+1:2];
            a_err   <= illegal;
            state   <= S_DATA;
            count   <= 4'(WAIT_STATES);
            ready_q <= (WAIT_STATES == 0);
        end else begin
            valid   <= 1'b0;
            state   <= S_IDLE;
            count   <= 4'd0;
            ready_q <= 1'b1;
        end
    end
`endif

endmodule
